// File: rtl/alu_status_unit.sv
// 16-bit two-operand ALU with combinational {N,V,Z} flags and a loadable status register.
// Define ALU_CARRY_EN to add the carry output c and its registered copy status_c.
module alu_status_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [1:0]       ALUop,
    input  logic             load_status,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       nvz,
`ifdef ALU_CARRY_EN
    output logic             c,
    output logic             status_c,
`endif
    output logic [2:0]       status
);

    localparam int MSB = WIDTH - 1;

    // The result carries one extra bit only when the carry out is actually observed.
`ifdef ALU_CARRY_EN
    localparam int RW = WIDTH + 1;
`else
    localparam int RW = WIDTH;
`endif

    logic [RW-1:0] res;
    logic          flag_n;
    logic          flag_v;
    logic          flag_z;
    logic [2:0]    status_d;
    logic [2:0]    status_q;

    always_comb begin
        res = '0;
        case (ALUop)
            2'b00:   res = RW'(Ain) + RW'(Bin);
            2'b01:   res = RW'(Ain) + RW'(~Bin) + RW'(1);
            2'b10:   res = RW'(Ain & Bin);
            default: res = RW'(~Bin);
        endcase
    end

    assign out = res[WIDTH-1:0];

    always_comb begin
        flag_n = out[MSB];
        flag_z = (out == '0);
        flag_v = 1'b0;
        case (ALUop)
            2'b00:   flag_v = (Ain[MSB] == Bin[MSB]) && (out[MSB] != Ain[MSB]);
            2'b01:   flag_v = (Ain[MSB] != Bin[MSB]) && (out[MSB] != Ain[MSB]);
            default: flag_v = 1'b0;
        endcase
    end

    assign nvz = {flag_n, flag_v, flag_z};

    always_comb begin
        status_d = load_status ? nvz : status_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= 3'b000;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;

`ifdef ALU_CARRY_EN
    logic carry;
    logic status_c_d;
    logic status_c_q;

    // For subtraction the top bit of Ain + ~Bin + 1 is the inverted borrow.
    always_comb begin
        carry = 1'b0;
        if (ALUop == 2'b00 || ALUop == 2'b01) begin
            carry = res[WIDTH];
        end
    end

    assign c = carry;

    always_comb begin
        status_c_d = load_status ? carry : status_c_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_c_q <= 1'b0;
        end else begin
            status_c_q <= status_c_d;
        end
    end

    assign status_c = status_c_q;
`endif

endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit: directed vectors, status register sequence,
// then randomized traffic compared every cycle against a signed-integer reference model.
module tb_alu_status_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] Ain = 16'h0;
    logic [15:0] Bin = 16'h0;
    logic [1:0]  ALUop = 2'b00;
    logic        load_status = 1'b0;
    logic [15:0] out;
    logic [2:0]  nvz;
    logic [2:0]  status;
`ifdef ALU_CARRY_EN
    logic        c;
    logic        status_c;
`endif

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    logic [2:0] exp_status = 3'b000;
    logic       exp_status_c = 1'b0;

    alu_status_unit #(.WIDTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .Ain(Ain),
        .Bin(Bin),
        .ALUop(ALUop),
        .load_status(load_status),
        .out(out),
        .nvz(nvz),
`ifdef ALU_CARRY_EN
        .c(c),
        .status_c(status_c),
`endif
        .status(status)
    );

    always #5 clk = ~clk;

    // Reference: signed/unsigned integer arithmetic, overflow judged by range of the true result.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                                  output logic [15:0] o, output logic [2:0] f, output logic cy);
        int sa;
        int sb;
        int ua;
        int ub;
        int s;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        v  = 1'b0;
        cy = 1'b0;
        case (op)
            2'd0: begin
                s  = sa + sb;
                o  = 16'(s);
                v  = (s > 32767) || (s < -32768);
                cy = (ua + ub) > 65535;
            end
            2'd1: begin
                s  = sa - sb;
                o  = 16'(s);
                v  = (s > 32767) || (s < -32768);
                cy = (ua >= ub);
            end
            2'd2: o = a & b;
            default: o = ~b;
        endcase
        f = {o[15], v, (o == 16'h0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic [15:0] mo;
        logic [2:0]  mf;
        logic        mc;
        if (reset) begin
            exp_status   = 3'b000;
            exp_status_c = 1'b0;
        end else if (load_status) begin
            model(Ain, Bin, ALUop, mo, mf, mc);
            exp_status   = mf;
            exp_status_c = mc;
        end
    end

    always @(negedge clk) begin
        logic [15:0] mo;
        logic [2:0]  mf;
        logic        mc;
        if (cmp_en) begin
            model(Ain, Bin, ALUop, mo, mf, mc);
            check("cyc_out", 32'(out), 32'(mo));
            check("cyc_nvz", 32'(nvz), 32'(mf));
            check("cyc_status", 32'(status), 32'(exp_status));
`ifdef ALU_CARRY_EN
            check("cyc_c", 32'(c), 32'(mc));
            check("cyc_status_c", 32'(status_c), 32'(exp_status_c));
`endif
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] o;
        logic [2:0]  f;
    } vec_t;

    vec_t dirs[8] = '{
        '{16'h000A, 16'h0001, 2'd0, 16'h000B, 3'b000},
        '{16'h000A, 16'h0001, 2'd1, 16'h0009, 3'b000},
        '{16'h000A, 16'h0001, 2'd2, 16'h0000, 3'b001},
        '{16'h000A, 16'h0001, 2'd3, 16'hFFFE, 3'b100},
        '{16'h7FF8, 16'h0020, 2'd0, 16'h8018, 3'b110},
        '{16'h8008, 16'h8040, 2'd0, 16'h0048, 3'b010},
        '{16'h8000, 16'h0001, 2'd1, 16'h7FFF, 3'b010},
        '{16'h1234, 16'h1234, 2'd1, 16'h0000, 3'b001}
    };

    logic [15:0] corners[6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF};

    function automatic logic [15:0] rand_operand();
        if ($urandom_range(0, 3) == 0) begin
            return corners[$urandom_range(0, 5)];
        end
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] mo;
        logic [2:0]  mf;
        logic        mc;

        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        check("reset_status", 32'(status), 32'(3'b000));
`ifdef ALU_CARRY_EN
        check("reset_status_c", 32'(status_c), 32'(1'b0));
`endif

        foreach (dirs[i]) begin
            Ain = dirs[i].a;
            Bin = dirs[i].b;
            ALUop = dirs[i].op;
            #1;
            check($sformatf("dir%0d_out", i), 32'(out), 32'(dirs[i].o));
            check($sformatf("dir%0d_nvz", i), 32'(nvz), 32'(dirs[i].f));
            model(dirs[i].a, dirs[i].b, dirs[i].op, mo, mf, mc);
            check($sformatf("dir%0d_model_out", i), 32'(mo), 32'(dirs[i].o));
            check($sformatf("dir%0d_model_nvz", i), 32'(mf), 32'(dirs[i].f));
        end

`ifdef ALU_CARRY_EN
        Ain = 16'hFFFF; Bin = 16'h0001; ALUop = 2'd0;
        #1;
        check("carry_add_out", 32'(out), 32'(16'h0000));
        check("carry_add_c", 32'(c), 32'(1'b1));
        check("carry_add_nvz", 32'(nvz), 32'(3'b001));
        Ain = 16'h0001; Bin = 16'h0002; ALUop = 2'd1;
        #1;
        check("carry_sub_c", 32'(c), 32'(1'b0));
        model(16'h0001, 16'h0002, 2'd1, mo, mf, mc);
        check("carry_sub_model_c", 32'(mc), 32'(1'b0));
`endif

        // Load while reset is held must not take effect on the deassertion edge's predecessor.
        load_status = 1'b1;
        Ain = 16'h7FF8; Bin = 16'h0020; ALUop = 2'd0;
        @(posedge clk); #1;
        check("load_in_reset", 32'(status), 32'(3'b000));
        @(negedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("load_110", 32'(status), 32'(3'b110));
        load_status = 1'b0;
        Ain = 16'h1234; Bin = 16'h1234; ALUop = 2'd1;
        @(posedge clk); #1;
        check("hold_110", 32'(status), 32'(3'b110));
        #2 reset = 1'b1;
        #1;
        check("async_clear", 32'(status), 32'(3'b000));
        load_status = 1'b1;
        Ain = 16'h8000; Bin = 16'h0001; ALUop = 2'd1;
        @(posedge clk); #1;
        check("reset_beats_load", 32'(status), 32'(3'b000));
        @(negedge clk); #1;
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            Ain = rand_operand();
            Bin = rand_operand();
            ALUop = 2'($urandom_range(0, 3));
            load_status = ($urandom_range(0, 2) != 0);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                #1 reset = 1'b1;
            end
        end

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
